dds_channel_scheduler: RTL and testbench

Time-multiplexes one `dds` core across `NUM_CH` independent NCO channels. It holds a phase accumulator, frequency word and phase offset per channel, and issues one phase word per cycle to the core's `s_axis_phase` input in round-robin order. It tags each issue with its channel number and re-attaches that tag to the matching `m_axis_out` sample, so downstream mixers receive channel-interleaved sin/cos with a channel ID and frame marker.

---
 rtl/dds_sched_pkg.sv | 18 +
 rtl/dds_tag_fifo.sv | 75 +++++++
 rtl/dds_channel_scheduler.sv | 143 ++++++++++++++
 tb/tb_dds_channel_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sched_pkg.sv
// rtl/dds_sched_pkg.sv - shared types and sizing for the DDS channel scheduler
package dds_sched_pkg;

    localparam int MAX_CH_W = 4;

    typedef logic [MAX_CH_W-1:0] ch_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Room for every tag in flight through the core plus the output register slack.
    function automatic int TAG_FIFO_DEPTH(input int max_dds_latency);
        return max_dds_latency + 2;
    endfunction

endpackage

// File: rtl/dds_tag_fifo.sv
// rtl/dds_tag_fifo.sv - channel tag FIFO between phase issue and core output
module dds_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees a slot in the same cycle, so push-while-full-and-popping is legal.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign overflow  = push && full && !do_pop;
    assign underflow = pop && empty;
    assign pop_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/dds_channel_scheduler.sv
// rtl/dds_channel_scheduler.sv - round-robin NCO channel scheduler around one shared dds core
module dds_channel_scheduler
    import dds_sched_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int PHASE_DW        = 16,
    parameter int OUT_DW          = 16,
    parameter int MAX_DDS_LATENCY = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        sync,
    input  logic                        cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
    input  logic [PHASE_DW-1:0]         cfg_freq,
    input  logic [PHASE_DW-1:0]         cfg_offset,
    output logic [PHASE_DW-1:0]         dds_phase_tdata,
    output logic                        dds_phase_tvalid,
    input  logic [2*OUT_DW-1:0]         dds_out_tdata,
    input  logic                        dds_out_tvalid,
    output logic [2*OUT_DW-1:0]         m_axis_tdata,
    output logic [$clog2(NUM_CH)-1:0]   m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    output logic                        tag_err
);

    localparam int CH_W       = $clog2(NUM_CH);
    localparam int FIFO_DEPTH = TAG_FIFO_DEPTH(MAX_DDS_LATENCY);

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [PHASE_DW-1:0] acc           [NUM_CH];
    logic [PHASE_DW-1:0] freq          [NUM_CH];
    logic [PHASE_DW-1:0] offset        [NUM_CH];
    logic [PHASE_DW-1:0] shadow_freq   [NUM_CH];
    logic [PHASE_DW-1:0] shadow_offset [NUM_CH];
    logic                sync_pending;

    logic                frame_start;
    logic                issue;
    logic                zero_acc;
    logic [PHASE_DW-1:0] cur_acc;
    logic [PHASE_DW-1:0] cur_freq;
    logic [PHASE_DW-1:0] cur_offset;

    logic [CH_W-1:0]     tag_data;
    logic                tag_full;
    logic                tag_empty;
    logic                tag_overflow;
    logic                tag_underflow;

    // At frame start the channel-0 issue already sees the freshly copied config and zeroed accumulators.
    always_comb begin
        frame_start = (state == IDLE) || (ch == '0);
        issue       = frame_start ? enable : 1'b1;
        zero_acc    = frame_start && (sync_pending || sync);
        cur_acc     = zero_acc ? '0 : acc[ch];
        cur_freq    = frame_start ? shadow_freq[ch] : freq[ch];
        cur_offset  = frame_start ? shadow_offset[ch] : offset[ch];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ch               <= '0;
            sync_pending     <= 1'b0;
            dds_phase_tdata  <= '0;
            dds_phase_tvalid <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]           <= '0;
                freq[k]          <= '0;
                offset[k]        <= '0;
                shadow_freq[k]   <= '0;
                shadow_offset[k] <= '0;
            end
        end else begin
            if (cfg_wr) begin
                shadow_freq[cfg_ch]   <= cfg_freq;
                shadow_offset[cfg_ch] <= cfg_offset;
            end
            if (frame_start) begin
                freq         <= shadow_freq;
                offset       <= shadow_offset;
                sync_pending <= 1'b0;
            end else if (sync) begin
                sync_pending <= 1'b1;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (issue && ch == CH_W'(k)) begin
                    acc[k] <= cur_acc + cur_freq;
                end else if (zero_acc) begin
                    acc[k] <= '0;
                end
            end
            dds_phase_tvalid <= issue;
            if (issue) begin
                dds_phase_tdata <= cur_acc + cur_offset;
                ch              <= ch + 1'b1;
                state           <= RUN;
            end else begin
                ch    <= '0;
                state <= IDLE;
            end
        end
    end

    dds_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (ch),
        .pop       (dds_out_tvalid),
        .pop_data  (tag_data),
        .full      (tag_full),
        .empty     (tag_empty),
        .overflow  (tag_overflow),
        .underflow (tag_underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            tag_err       <= 1'b0;
        end else begin
            m_axis_tvalid <= dds_out_tvalid;
            m_axis_tlast  <= dds_out_tvalid && !tag_underflow && (tag_data == CH_W'(NUM_CH - 1));
            if (dds_out_tvalid) begin
                m_axis_tdata <= dds_out_tdata;
                m_axis_tuser <= tag_underflow ? '0 : tag_data;
            end
            tag_err <= tag_err | tag_overflow | tag_underflow | (tag_full & tag_empty);
        end
    end

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// tb/tb_dds_channel_scheduler.sv - self-checking bench for dds_channel_scheduler
module tb_dds_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int PW     = 16;
    localparam int LAT    = 9;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sync;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_freq;
    logic [15:0] cfg_offset;
    logic [15:0] dds_phase_tdata;
    logic        dds_phase_tvalid;
    logic [31:0] dds_out_tdata;
    logic        dds_out_tvalid;
    logic [31:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        tag_err;

    dds_channel_scheduler #(
        .NUM_CH          (NUM_CH),
        .PHASE_DW        (PW),
        .OUT_DW          (16),
        .MAX_DDS_LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sync             (sync),
        .cfg_wr           (cfg_wr),
        .cfg_ch           (cfg_ch),
        .cfg_freq         (cfg_freq),
        .cfg_offset       (cfg_offset),
        .dds_phase_tdata  (dds_phase_tdata),
        .dds_phase_tvalid (dds_phase_tvalid),
        .dds_out_tdata    (dds_out_tdata),
        .dds_out_tvalid   (dds_out_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .tag_err          (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in core: fixed latency, sample = {phase, phase ^ A5A5}
    logic [15:0] pipe_d [LAT];
    logic        pipe_v [LAT];
    logic        force_out_valid;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= dds_phase_tvalid;
            pipe_d[0] <= dds_phase_tdata;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign dds_out_tvalid = pipe_v[LAT-1] | force_out_valid;
    assign dds_out_tdata  = {pipe_d[LAT-1], pipe_d[LAT-1] ^ 16'hA5A5};

    int tests = 0;
    int fails = 0;
    int m_count = 0;
    bit expect_underflow = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: config snapshot and sync taken whenever the frame position is 0
    typedef struct {
        int          ch;
        logic [15:0] ph;
    } sample_t;

    sample_t     sb[$];
    logic [15:0] m_acc [NUM_CH];
    logic [15:0] m_freq [NUM_CH];
    logic [15:0] m_off [NUM_CH];
    logic [15:0] m_sh_freq [NUM_CH];
    logic [15:0] m_sh_off [NUM_CH];
    int          m_pos;
    bit          m_running;
    bit          m_sync_pend;
    bit          exp_v;
    logic [15:0] exp_ph;

    function automatic void model_step();
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_acc[k] = 0; m_freq[k] = 0; m_off[k] = 0; m_sh_freq[k] = 0; m_sh_off[k] = 0;
            end
            m_pos = 0; m_running = 0; m_sync_pend = 0; exp_v = 0; exp_ph = 0;
            sb.delete();
            return;
        end
        if (m_pos == 0) begin
            m_freq = m_sh_freq;
            m_off  = m_sh_off;
            m_running = enable;
            if (m_sync_pend || sync) begin
                for (int k = 0; k < NUM_CH; k++) m_acc[k] = 0;
            end
            m_sync_pend = 0;
        end else if (sync) begin
            m_sync_pend = 1;
        end
        exp_v = m_running;
        if (m_running) begin
            exp_ph = m_acc[m_pos] + m_off[m_pos];
            m_acc[m_pos] = m_acc[m_pos] + m_freq[m_pos];
            sb.push_back('{m_pos, exp_ph});
            m_pos = (m_pos + 1) % NUM_CH;
        end
        if (cfg_wr) begin
            m_sh_freq[cfg_ch] = cfg_freq;
            m_sh_off[cfg_ch]  = cfg_offset;
        end
    endfunction

    task automatic check_outputs();
        sample_t s;
        chk("phase_tvalid", 32'(dds_phase_tvalid), 32'(exp_v));
        if (exp_v) chk("phase_tdata", 32'(dds_phase_tdata), 32'(exp_ph));
        if (m_axis_tvalid) begin
            m_count++;
            if (expect_underflow) begin
                chk("underflow_tuser", 32'(m_axis_tuser), 32'd0);
                chk("underflow_tlast", 32'(m_axis_tlast), 32'd0);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m_axis_unexpected: got tvalid 1 expected no sample");
            end else begin
                s = sb.pop_front();
                chk("m_tdata", m_axis_tdata, {s.ph, s.ph ^ 16'hA5A5});
                chk("m_tuser", 32'(m_axis_tuser), 32'(s.ch));
                chk("m_tlast", 32'(m_axis_tlast), 32'(s.ch == NUM_CH - 1));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; sync = 0; cfg_wr = 0;
        cycle();
        reset = 0;
    endtask

    task automatic write_cfg(input int c, input logic [15:0] f, input logic [15:0] o);
        cfg_wr = 1; cfg_ch = 2'(c); cfg_freq = f; cfg_offset = o;
        cycle();
        cfg_wr = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        bit          en;
        bit          v;
        logic [15:0] ph;
    } vec_t;

    vec_t        vec [12];
    logic [15:0] exp_list [4];

    initial begin
        reset = 1; enable = 0; sync = 0; cfg_wr = 0; cfg_ch = 0;
        cfg_freq = 0; cfg_offset = 0; force_out_valid = 0;
        do_reset();

        // reset state
        chk("rst_phase_tvalid", 32'(dds_phase_tvalid), 32'd0);
        chk("rst_phase_tdata", 32'(dds_phase_tdata), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tag_err", 32'(tag_err), 32'd0);

        // basic round robin, then enable dropped at ch1
        vec[0]  = '{1, 1, 16'h0000}; vec[1]  = '{1, 1, 16'h0000};
        vec[2]  = '{1, 1, 16'h0000}; vec[3]  = '{1, 1, 16'h0000};
        vec[4]  = '{1, 1, 16'h0100}; vec[5]  = '{0, 1, 16'h0200};
        vec[6]  = '{0, 1, 16'h0400}; vec[7]  = '{0, 1, 16'h0800};
        vec[8]  = '{0, 0, 16'h0000}; vec[9]  = '{0, 0, 16'h0000};
        vec[10] = '{0, 0, 16'h0000}; vec[11] = '{0, 0, 16'h0000};
        for (int k = 0; k < NUM_CH; k++) write_cfg(k, 16'h0100 << k, 16'h0000);
        m_count = 0;
        for (int i = 0; i < 12; i++) begin
            enable = vec[i].en;
            cycle();
            chk($sformatf("t1_tvalid[%0d]", i), 32'(dds_phase_tvalid), 32'(vec[i].v));
            if (vec[i].v) chk($sformatf("t1_tdata[%0d]", i), 32'(dds_phase_tdata), 32'(vec[i].ph));
        end
        idle_cycles(14);
        chk("t1_m_count", 32'(m_count), 32'd8);
        chk("t1_tag_err", 32'(tag_err), 32'd0);

        // mid-frame config write on ch2, last write wins
        do_reset();
        write_cfg(2, 16'h0100, 16'h0000);
        exp_list[0] = 16'h0000; exp_list[1] = 16'h0100;
        exp_list[2] = 16'h4100; exp_list[3] = 16'h8100;
        enable = 1;
        for (int i = 0; i < 15; i++) begin
            cfg_wr = (i == 1 || i == 2); cfg_ch = 2'd2; cfg_offset = 16'h0000;
            cfg_freq = (i == 1) ? 16'h1000 : 16'h4000;
            cycle();
            if (i % 4 == 2) chk($sformatf("t2_ch2[%0d]", i / 4), 32'(dds_phase_tdata), 32'(exp_list[i / 4]));
        end
        cfg_wr = 0;

        // phase wrap on ch1
        do_reset();
        write_cfg(1, 16'hFFFF, 16'h0002);
        exp_list[0] = 16'h0002; exp_list[1] = 16'h0001;
        exp_list[2] = 16'h0000; exp_list[3] = 16'hFFFF;
        enable = 1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (i % 4 == 1) chk($sformatf("t3_ch1[%0d]", i / 4), 32'(dds_phase_tdata), 32'(exp_list[i / 4]));
        end
        enable = 0;
        idle_cycles(16);
        chk("t3_tag_err", 32'(tag_err), 32'd0);

        // sync mid-frame
        do_reset();
        for (int k = 0; k < NUM_CH; k++) write_cfg(k, 16'(16'h0100 * (k + 1)), 16'(16'h0010 * (k + 1)));
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            sync = (i == 5);
            cycle();
            if (i == 6) chk("t4_ch2_before", 32'(dds_phase_tdata), 32'h0330);
            if (i == 7) chk("t4_ch3_before", 32'(dds_phase_tdata), 32'h0440);
            if (i >= 8) chk($sformatf("t4_after[%0d]", i - 8), 32'(dds_phase_tdata), 32'(16'h0010 * (i - 7)));
        end
        sync = 0;

        // reset while samples in flight, then forced underflow
        do_reset();
        write_cfg(0, 16'h1234, 16'h0000);
        enable = 1;
        for (int i = 0; i < 7; i++) cycle();
        reset = 1;
        cycle();
        reset = 0; enable = 0;
        chk("t6_phase_tvalid", 32'(dds_phase_tvalid), 32'd0);
        chk("t6_phase_tdata", 32'(dds_phase_tdata), 32'd0);
        chk("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_m_tdata", m_axis_tdata, 32'd0);
        chk("t6_m_tuser", 32'(m_axis_tuser), 32'd0);
        m_count = 0;
        idle_cycles(15);
        chk("t6_no_stale", 32'(m_count), 32'd0);
        expect_underflow = 1;
        force_out_valid = 1;
        cycle();
        force_out_valid = 0;
        chk("t6_forced_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("t6_tag_err_set", 32'(tag_err), 32'd1);
        idle_cycles(5);
        expect_underflow = 0;
        chk("t6_tag_err_sticky", 32'(tag_err), 32'd1);
        do_reset();
        chk("t6_tag_err_clear", 32'(tag_err), 32'd0);

        // randomized run against the reference model
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 99) < 85);
            sync   = ($urandom_range(0, 99) < 4);
            cfg_wr = ($urandom_range(0, 99) < 25);
            cfg_ch = 2'($urandom_range(0, NUM_CH - 1));
            cfg_freq = 16'($urandom);
            cfg_offset = 16'($urandom);
            cycle();
        end
        enable = 0; sync = 0; cfg_wr = 0;
        idle_cycles(20);
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_tag_err", 32'(tag_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
